// File: rtl/sq_wave_meter_pkg.sv
//==============================================================================
// Module      : sq_wave_meter_pkg
// Description : Shared constants, FSM encodings and ms-to-cycles helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sq_wave_meter_pkg;

    localparam int c_default_clock_frequency = 27000000;

    localparam logic [1:0] ST_ACQUIRE   = 2'd0;
    localparam logic [1:0] ST_MEAS_HIGH = 2'd1;
    localparam logic [1:0] ST_MEAS_LOW  = 2'd2;

    // 64-bit intermediate keeps 27 MHz * 1000 ms from overflowing.
    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        longint v;
        v = (longint'(freq_hz) * longint'(ms)) / 64'sd1000;
        return int'(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
//==============================================================================
// Module      : sync_edge_detect
// Description : Multi-flop synchroniser with single-cycle rise/fall detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  =  r_sync[SYNC_STAGES-1] & ~r_s_d;
    assign fall  = ~r_sync[SYNC_STAGES-1] &  r_s_d;

endmodule

`default_nettype wire

// File: rtl/sq_wave_meter.sv
//==============================================================================
// Module      : sq_wave_meter
// Description : Measures high time, low time and period of a square wave pin,
//               flagging loss of signal after a no-edge timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sq_wave_meter
    import sq_wave_meter_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = c_default_clock_frequency,
    parameter int COUNT_WIDTH     = 24,
    parameter int TIMEOUT_MS      = 1000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   IO_in,
    output logic [COUNT_WIDTH-1:0] High_cycles,
    output logic [COUNT_WIDTH-1:0] Low_cycles,
    output logic [COUNT_WIDTH:0]   Period_cycles,
    output logic                   Meas_valid,
    output logic                   Signal_lost,
    output logic                   Level
);

    localparam int                     c_timeout_int = ms_to_cycles(CLOCK_FREQUENCY, TIMEOUT_MS) - 1;
    localparam logic [COUNT_WIDTH-1:0] c_timeout     = COUNT_WIDTH'(c_timeout_int);
    localparam logic [COUNT_WIDTH-1:0] c_cnt_max     = '1;
    localparam logic [COUNT_WIDTH-1:0] c_one         = COUNT_WIDTH'(1);

    logic                   w_level;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic                   w_timeout;
    logic [COUNT_WIDTH-1:0] r_run_cnt;
    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic                   w_latch_high;
    logic                   w_latch_low;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .async_in (IO_in),
        .level    (w_level),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    assign w_edge    = w_rise | w_fall;
    // An edge in the same cycle as the timeout match wins.
    assign w_timeout = ~w_edge & (r_run_cnt == c_timeout);
    assign Level     = w_level;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_run_cnt <= '0;
        end else if (w_edge) begin
            r_run_cnt <= c_one;
        end else if (r_run_cnt != c_cnt_max) begin
            r_run_cnt <= r_run_cnt + c_one;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= ST_ACQUIRE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACQUIRE:   if (w_rise) w_next_state = ST_MEAS_HIGH;
            ST_MEAS_HIGH: if (w_fall) w_next_state = ST_MEAS_LOW;
            ST_MEAS_LOW:  if (w_rise) w_next_state = ST_MEAS_HIGH;
            default:      w_next_state = ST_ACQUIRE;
        endcase
        if (w_timeout) begin
            w_next_state = ST_ACQUIRE;
        end
    end

    always_comb begin
        w_latch_high = 1'b0;
        w_latch_low  = 1'b0;
        case (r_state)
            ST_MEAS_HIGH: w_latch_high = w_fall;
            ST_MEAS_LOW:  w_latch_low  = w_rise;
            default:      ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            High_cycles   <= '0;
            Low_cycles    <= '0;
            Period_cycles <= '0;
            Meas_valid    <= 1'b0;
            Signal_lost   <= 1'b0;
        end else begin
            Meas_valid <= w_latch_low;
            if (w_latch_high) begin
                High_cycles <= r_run_cnt;
            end
            if (w_latch_low) begin
                Low_cycles    <= r_run_cnt;
                Period_cycles <= {1'b0, High_cycles} + {1'b0, r_run_cnt};
            end
            if (w_timeout) begin
                Signal_lost <= 1'b1;
            end else if (w_latch_low) begin
                Signal_lost <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sq_wave_meter.sv
//==============================================================================
// Module      : tb_sq_wave_meter
// Description : Scoreboard bench for sq_wave_meter (SYNC_STAGES 2 and 3).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sq_wave_meter;

    localparam int CW = 24;

    typedef struct {
        int high;
        int low;
        int period;
    } meas_t;

    logic          clk = 1'b0;
    logic          Reset_n;
    logic          IO_in;
    logic [CW-1:0] high2, low2, high3, low3;
    logic [CW:0]   per2, per3;
    logic          mv2, lost2, lvl2, mv3, lost3, lvl3;

    int    checks   = 0;
    int    failures = 0;
    meas_t q[$];

    always #5 clk = ~clk;

    sq_wave_meter #(
        .CLOCK_FREQUENCY (1000),
        .COUNT_WIDTH     (CW),
        .TIMEOUT_MS      (50),
        .SYNC_STAGES     (2)
    ) dut2 (
        .Clock         (clk),
        .Reset_n       (Reset_n),
        .IO_in         (IO_in),
        .High_cycles   (high2),
        .Low_cycles    (low2),
        .Period_cycles (per2),
        .Meas_valid    (mv2),
        .Signal_lost   (lost2),
        .Level         (lvl2)
    );

    sq_wave_meter #(
        .CLOCK_FREQUENCY (1000),
        .COUNT_WIDTH     (CW),
        .TIMEOUT_MS      (50),
        .SYNC_STAGES     (3)
    ) dut3 (
        .Clock         (clk),
        .Reset_n       (Reset_n),
        .IO_in         (IO_in),
        .High_cycles   (high3),
        .Low_cycles    (low3),
        .Period_cycles (per3),
        .Meas_valid    (mv3),
        .Signal_lost   (lost3),
        .Level         (lvl3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int h, input int l, input int p);
        meas_t m;
        m.high = h; m.low = l; m.period = p;
        q.push_back(m);
    endtask

    task automatic hold(input logic v, input int n);
        IO_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every Meas_valid of the SYNC_STAGES=2 instance must match the queue head.
    always @(negedge clk) begin
        if (Reset_n === 1'b1 && mv2 !== 1'b0) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got Meas_valid=%b with nothing expected (t=%0t)", mv2, $time);
            end else begin
                meas_t e;
                e = q.pop_front();
                chk("valid_high",   longint'(high2), longint'(e.high));
                chk("valid_low",    longint'(low2),  longint'(e.low));
                chk("valid_period", longint'(per2),  longint'(e.period));
                chk("valid_lost_clear", longint'(lost2), 0);
            end
        end
    end

    initial begin
        Reset_n = 1'b0;
        IO_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_high",   longint'(high2), 0);
        chk("rst_low",    longint'(low2),  0);
        chk("rst_period", longint'(per2),  0);
        chk("rst_valid",  longint'(mv2),   0);
        chk("rst_lost",   longint'(lost2), 0);
        chk("rst_level",  longint'(lvl2),  0);
        Reset_n = 1'b1;

        // Partial low phase after reset is discarded; first triple is 6/2.
        hold(1'b0, 4);
        hold(1'b1, 6);
        hold(1'b0, 2);
        push(6, 2, 8);

        // Four 5-high / 3-low periods.
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 5);
            hold(1'b0, 3);
            push(5, 3, 8);
        end
        hold(1'b1, 5);
        chk("run_lost", longint'(lost2), 0);
        chk("run_level_high", longint'(lvl2), 1);

        // Loss of signal: fall then 60 low cycles.
        IO_in = 1'b0;
        repeat (51) @(posedge clk);
        #1;
        chk("lost_before_timeout", longint'(lost2), 0);
        step();
        chk("lost_at_timeout", longint'(lost2), 1);
        chk("lost_hold_high",   longint'(high2), 5);
        chk("lost_hold_low",    longint'(low2),  3);
        chk("lost_hold_period", longint'(per2),  8);
        repeat (8) @(posedge clk);
        #1;
        chk("lost_sticky", longint'(lost2), 1);

        // Recovery needs one full period; the first rise only re-acquires.
        hold(1'b1, 5);
        hold(1'b0, 3);
        push(5, 3, 8);

        // 1-cycle high pulses, then asymmetric 40/9.
        hold(1'b1, 1);
        hold(1'b0, 7);
        push(1, 7, 8);
        hold(1'b1, 1);
        hold(1'b0, 7);
        push(1, 7, 8);
        hold(1'b1, 40);
        hold(1'b0, 9);
        push(40, 9, 49);
        hold(1'b1, 5);
        chk("asym_no_lost", longint'(lost2), 0);

        // Reset in the middle of a low phase.
        hold(1'b0, 4);
        Reset_n = 1'b0;
        step();
        chk("mrst_high",   longint'(high2), 0);
        chk("mrst_low",    longint'(low2),  0);
        chk("mrst_period", longint'(per2),  0);
        chk("mrst_valid",  longint'(mv2),   0);
        chk("mrst_lost",   longint'(lost2), 0);
        chk("mrst_level",  longint'(lvl2),  0);
        Reset_n = 1'b1;
        hold(1'b0, 2);
        hold(1'b1, 5);
        hold(1'b0, 3);
        push(5, 3, 8);

        // Latency of a single rise for SYNC_STAGES 2 and 3.
        IO_in = 1'b1;
        step();
        chk("lat_n1_level2", longint'(lvl2), 0);
        step();
        chk("lat_n2_level2", longint'(lvl2), 1);
        chk("lat_n2_valid2", longint'(mv2),  0);
        chk("lat_n2_level3", longint'(lvl3), 0);
        step();
        chk("lat_n3_valid2", longint'(mv2),  1);
        chk("lat_n3_level3", longint'(lvl3), 1);
        chk("lat_n3_valid3", longint'(mv3),  0);
        step();
        chk("lat_n4_valid3", longint'(mv3),  1);
        chk("lat_n4_valid2", longint'(mv2),  0);
        chk("lat_n4_low3",   longint'(low3), 3);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", longint'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
